// File: rtl/decoder_grant_arbiter.sv
// Four-requester round-robin grant arbiter with a bounded hold time.
// Grants are one-hot registered outputs; every grant is followed by a one-cycle GAP.
module decoder_grant_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_idx;
    logic       r_gnt_valid;
    logic       r_timeout;

    state_t     w_nxt_state;
    logic [1:0] w_nxt_ptr;
    logic [7:0] w_nxt_hold;
    logic [1:0] w_nxt_idx;
    logic       w_nxt_valid;
    logic       w_nxt_timeout;
    logic [3:0] w_nxt_gnt;

    logic [7:0] w_req_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_pick;
    logic       w_found;
    logic       w_keep;

    // Rotate so bit 0 is the requester at ptr; first set bit is the winner.
    assign w_req_dbl = {req, req} >> r_ptr;
    assign w_rot     = w_req_dbl[3:0];
    assign w_found   = |w_rot;
    assign w_pick    = r_ptr + w_off;
    assign w_keep    = req[r_gnt_idx] & en;

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_ptr     = r_ptr;
        w_nxt_hold    = r_hold_cnt;
        w_nxt_idx     = 2'd0;
        w_nxt_valid   = 1'b0;
        w_nxt_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_found) begin
                    w_nxt_state = S_GRANT;
                    w_nxt_idx   = w_pick;
                    w_nxt_valid = 1'b1;
                    w_nxt_hold  = 8'd0;
                end
            end
            S_GRANT: begin
                if (w_keep && (r_hold_cnt < HOLD_LAST)) begin
                    w_nxt_idx   = r_gnt_idx;
                    w_nxt_valid = 1'b1;
                    w_nxt_hold  = r_hold_cnt + 8'd1;
                end else begin
                    // A drop of req or en on the last hold cycle counts as a normal release.
                    w_nxt_state   = S_GAP;
                    w_nxt_ptr     = r_gnt_idx + 2'd1;
                    w_nxt_timeout = w_keep && (r_hold_cnt == HOLD_LAST);
                end
            end
            S_GAP: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        w_nxt_gnt = w_nxt_valid ? (4'b0001 << w_nxt_idx) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_hold_cnt  <= 8'd0;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_ptr       <= w_nxt_ptr;
            r_hold_cnt  <= w_nxt_hold;
            r_gnt       <= w_nxt_gnt;
            r_gnt_idx   <= w_nxt_idx;
            r_gnt_valid <= w_nxt_valid;
            r_timeout   <= w_nxt_timeout;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
